// File: rtl/mux_nx1_rr.sv
// Registered N:1 arbitrating mux with valid/ready on every port and a one-entry output register.
// Define MUX_NX1_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mux_nx1_rr #(
  parameter int dataWidth = 32,
  parameter int numInputs = 4,
  parameter int selWidth  = $clog2(numInputs)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numInputs*dataWidth-1:0] in_data,
  input  logic [numInputs-1:0]           in_valid,
  output logic [numInputs-1:0]           in_ready,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [selWidth-1:0]            out_sel
);

  logic [dataWidth-1:0] data_p0;
  logic [selWidth-1:0]  sel_p0;
  logic                 vld_p0;

  logic                 load;
  logic                 any_vld;
  logic [selWidth-1:0]  gnt;
  logic [dataWidth-1:0] gnt_data;

  assign load = !rst && (!vld_p0 || out_ready);

`ifdef MUX_NX1_FIXED_PRIO_EN
  // Scan from the top down so the lowest-index valid channel is the last to write gnt.
  always_comb begin
    gnt     = '0;
    any_vld = 1'b0;
    for (int i = numInputs - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        gnt     = selWidth'(i);
        any_vld = 1'b1;
      end
    end
  end
`else
  logic [selWidth-1:0] ptr;
  logic [selWidth:0]   pos;

  function automatic logic [selWidth-1:0] wrap_inc(input logic [selWidth-1:0] v);
    return (v == selWidth'(numInputs - 1)) ? '0 : v + 1'b1;
  endfunction

  // pos is one bit wider so ptr+k can exceed numInputs before the modulo fold.
  always_comb begin
    gnt     = '0;
    any_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < numInputs; k++) begin
      pos = {1'b0, ptr} + (selWidth+1)'(k);
      if (pos >= (selWidth+1)'(numInputs))
        pos = pos - (selWidth+1)'(numInputs);
      if (!any_vld && in_valid[pos[selWidth-1:0]]) begin
        gnt     = pos[selWidth-1:0];
        any_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (load && any_vld)
      ptr <= wrap_inc(gnt);
  end
`endif

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < numInputs; i++) begin
      if (gnt == selWidth'(i))
        gnt_data = in_data[i*dataWidth +: dataWidth];
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && any_vld)
      in_ready[gnt] = 1'b1;
  end

  // p0: output register; data and select hold when the load cycle sees no requester
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
    end else if (load) begin
      vld_p0 <= any_vld;
      if (any_vld) begin
        data_p0 <= gnt_data;
        sel_p0  <= gnt;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_sel   = sel_p0;
  assign out_valid = vld_p0;

endmodule
